// File: rtl/triangle_setup.sv
// Triangle setup stage: computes 2*area, fixes winding, culls degenerate triangles
// and produces an 8.24-style reciprocal of 2*area before handing the triangle on.
module triangle_setup #(
    parameter int FRAC_BITS     = 24,
    parameter bit WAIT_FOR_DONE = 1'b1
) (
    input  logic        axi_aclk,
    input  logic        axi_areset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [8:0]  in_v1x,
    input  logic [8:0]  in_v2x,
    input  logic [8:0]  in_v3x,
    input  logic [7:0]  in_v1y,
    input  logic [7:0]  in_v2y,
    input  logic [7:0]  in_v3y,
    input  logic [15:0] in_z1,
    input  logic [15:0] in_z2,
    input  logic [15:0] in_z3,
    input  logic [7:0]  in_color,
    output logic [8:0]  v1x,
    output logic [8:0]  v2x,
    output logic [8:0]  v3x,
    output logic [7:0]  v1y,
    output logic [7:0]  v2y,
    output logic [7:0]  v3y,
    output logic [15:0] z1,
    output logic [15:0] z2,
    output logic [15:0] z3,
    output logic [7:0]  color,
    output logic [31:0] inv_area,
    output logic        triangle_valid,
    input  logic        triangle_ready,
    input  logic        rasterizer_done,
    output logic        busy,
    output logic        tri_dropped,
    output logic [15:0] tri_count
);

    localparam int QW = FRAC_BITS + 1;
    localparam int CW = $clog2(FRAC_BITS + 1);
    localparam logic [CW-1:0] LAST_ITER = CW'(FRAC_BITS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_AREA,
        S_DIV,
        S_ISSUE,
        S_WAIT_DONE
    } state_t;

    state_t state_q, state_d;

    logic [8:0]  v1x_q, v2x_q, v3x_q, v1x_d, v2x_d, v3x_d;
    logic [7:0]  v1y_q, v2y_q, v3y_q, v1y_d, v2y_d, v3y_d;
    logic [15:0] z1_q, z2_q, z3_q, z1_d, z2_d, z3_d;
    logic [7:0]  color_q, color_d;
    logic [17:0] area_q, area_d;
    logic [17:0] rem_q, rem_d;
    logic [QW-1:0] quot_q, quot_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0] inv_area_q, inv_area_d;
    logic        valid_q, valid_d;
    logic        dropped_q, dropped_d;
    logic [15:0] count_q, count_d;

    // Signed 20-bit twice-area; vertex coordinates are unsigned, so zero-extend first.
    logic signed [19:0] x1_s, x2_s, x3_s;
    logic signed [19:0] dy23, dy31, dy12;
    logic signed [19:0] area_s;
    logic [17:0]        area_mag;

    always_comb begin
        x1_s     = $signed({11'd0, v1x_q});
        x2_s     = $signed({11'd0, v2x_q});
        x3_s     = $signed({11'd0, v3x_q});
        dy23     = $signed({12'd0, v2y_q}) - $signed({12'd0, v3y_q});
        dy31     = $signed({12'd0, v3y_q}) - $signed({12'd0, v1y_q});
        dy12     = $signed({12'd0, v1y_q}) - $signed({12'd0, v2y_q});
        area_s   = x1_s * dy23 + x2_s * dy31 + x3_s * dy12;
        area_mag = area_s[19] ? 18'(-area_s) : area_s[17:0];
    end

    // Restoring divider step: the dividend 2^FRAC_BITS contributes a single 1 on the first step.
    logic [18:0] rem_shift;
    logic        rem_ge;

    always_comb begin
        rem_shift = {rem_q, (cnt_q == '0)};
        rem_ge    = (rem_shift >= {1'b0, area_q});
    end

    always_comb begin
        state_d    = state_q;
        v1x_d      = v1x_q;
        v2x_d      = v2x_q;
        v3x_d      = v3x_q;
        v1y_d      = v1y_q;
        v2y_d      = v2y_q;
        v3y_d      = v3y_q;
        z1_d       = z1_q;
        z2_d       = z2_q;
        z3_d       = z3_q;
        color_d    = color_q;
        area_d     = area_q;
        rem_d      = rem_q;
        quot_d     = quot_q;
        cnt_d      = cnt_q;
        inv_area_d = inv_area_q;
        valid_d    = valid_q;
        dropped_d  = 1'b0;
        count_d    = count_q;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    v1x_d   = in_v1x;
                    v2x_d   = in_v2x;
                    v3x_d   = in_v3x;
                    v1y_d   = in_v1y;
                    v2y_d   = in_v2y;
                    v3y_d   = in_v3y;
                    z1_d    = in_z1;
                    z2_d    = in_z2;
                    z3_d    = in_z3;
                    color_d = in_color;
                    state_d = S_AREA;
                end
            end

            S_AREA: begin
                if (area_s == '0) begin
                    dropped_d = 1'b1;
                    state_d   = S_IDLE;
                end else begin
                    // Negative area means clockwise winding: swap v2/v3 to normalise.
                    if (area_s[19]) begin
                        v2x_d = v3x_q;
                        v3x_d = v2x_q;
                        v2y_d = v3y_q;
                        v3y_d = v2y_q;
                        z2_d  = z3_q;
                        z3_d  = z2_q;
                    end
                    area_d  = area_mag;
                    rem_d   = '0;
                    quot_d  = '0;
                    cnt_d   = '0;
                    state_d = S_DIV;
                end
            end

            S_DIV: begin
                rem_d  = rem_ge ? 18'(rem_shift - {1'b0, area_q}) : 18'(rem_shift);
                quot_d = {quot_q[QW-2:0], rem_ge};
                cnt_d  = cnt_q + CW'(1);
                if (cnt_q == LAST_ITER) begin
                    state_d = S_ISSUE;
                end
            end

            S_ISSUE: begin
                // First ISSUE cycle publishes the quotient; valid is purely registered.
                if (!valid_q) begin
                    valid_d    = 1'b1;
                    inv_area_d = 32'(quot_q);
                end else if (triangle_ready) begin
                    valid_d = 1'b0;
                    count_d = count_q + 16'd1;
                    state_d = WAIT_FOR_DONE ? S_WAIT_DONE : S_IDLE;
                end
            end

            S_WAIT_DONE: begin
                if (rasterizer_done) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge axi_aclk) begin
        if (axi_areset) begin
            state_q    <= S_IDLE;
            v1x_q      <= '0;
            v2x_q      <= '0;
            v3x_q      <= '0;
            v1y_q      <= '0;
            v2y_q      <= '0;
            v3y_q      <= '0;
            z1_q       <= '0;
            z2_q       <= '0;
            z3_q       <= '0;
            color_q    <= '0;
            area_q     <= '0;
            rem_q      <= '0;
            quot_q     <= '0;
            cnt_q      <= '0;
            inv_area_q <= '0;
            valid_q    <= 1'b0;
            dropped_q  <= 1'b0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            v1x_q      <= v1x_d;
            v2x_q      <= v2x_d;
            v3x_q      <= v3x_d;
            v1y_q      <= v1y_d;
            v2y_q      <= v2y_d;
            v3y_q      <= v3y_d;
            z1_q       <= z1_d;
            z2_q       <= z2_d;
            z3_q       <= z3_d;
            color_q    <= color_d;
            area_q     <= area_d;
            rem_q      <= rem_d;
            quot_q     <= quot_d;
            cnt_q      <= cnt_d;
            inv_area_q <= inv_area_d;
            valid_q    <= valid_d;
            dropped_q  <= dropped_d;
            count_q    <= count_d;
        end
    end

    assign in_ready       = (state_q == S_IDLE);
    assign busy           = (state_q != S_IDLE);
    assign triangle_valid = valid_q;
    assign tri_dropped    = dropped_q;
    assign tri_count      = count_q;
    assign inv_area       = inv_area_q;
    assign v1x            = v1x_q;
    assign v2x            = v2x_q;
    assign v3x            = v3x_q;
    assign v1y            = v1y_q;
    assign v2y            = v2y_q;
    assign v3y            = v3y_q;
    assign z1             = z1_q;
    assign z2             = z2_q;
    assign z3             = z3_q;
    assign color          = color_q;

endmodule

// File: tb/tb_triangle_setup.sv
// Directed bench for triangle_setup: area/reciprocal, winding swap, cull, stalls,
// done handshake and mid-divide reset.
module tb_triangle_setup;

    logic        clk = 1'b0;
    logic        axi_areset;
    logic        in_valid;
    logic        in_ready;
    logic [8:0]  in_v1x, in_v2x, in_v3x;
    logic [7:0]  in_v1y, in_v2y, in_v3y;
    logic [15:0] in_z1, in_z2, in_z3;
    logic [7:0]  in_color;
    logic [8:0]  v1x, v2x, v3x;
    logic [7:0]  v1y, v2y, v3y;
    logic [15:0] z1, z2, z3;
    logic [7:0]  color;
    logic [31:0] inv_area;
    logic        triangle_valid;
    logic        triangle_ready;
    logic        rasterizer_done;
    logic        busy;
    logic        tri_dropped;
    logic [15:0] tri_count;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    triangle_setup #(.FRAC_BITS(24), .WAIT_FOR_DONE(1'b1)) dut (
        .axi_aclk       (clk),
        .axi_areset     (axi_areset),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_v1x         (in_v1x),
        .in_v2x         (in_v2x),
        .in_v3x         (in_v3x),
        .in_v1y         (in_v1y),
        .in_v2y         (in_v2y),
        .in_v3y         (in_v3y),
        .in_z1          (in_z1),
        .in_z2          (in_z2),
        .in_z3          (in_z3),
        .in_color       (in_color),
        .v1x            (v1x),
        .v2x            (v2x),
        .v3x            (v3x),
        .v1y            (v1y),
        .v2y            (v2y),
        .v3y            (v3y),
        .z1             (z1),
        .z2             (z2),
        .z3             (z3),
        .color          (color),
        .inv_area       (inv_area),
        .triangle_valid (triangle_valid),
        .triangle_ready (triangle_ready),
        .rasterizer_done(rasterizer_done),
        .busy           (busy),
        .tri_dropped    (tri_dropped),
        .tri_count      (tri_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic load(input logic [8:0] ax, input logic [7:0] ay,
                        input logic [8:0] bx, input logic [7:0] by,
                        input logic [8:0] cx, input logic [7:0] cy,
                        input logic [15:0] za, input logic [15:0] zb,
                        input logic [15:0] zc, input logic [7:0] col);
        in_v1x = ax; in_v1y = ay;
        in_v2x = bx; in_v2y = by;
        in_v3x = cx; in_v3y = cy;
        in_z1 = za; in_z2 = zb; in_z3 = zc;
        in_color = col;
    endtask

    // Present one triangle for a single accepting edge; returns at the negedge after it.
    task automatic send(input logic [8:0] ax, input logic [7:0] ay,
                        input logic [8:0] bx, input logic [7:0] by,
                        input logic [8:0] cx, input logic [7:0] cy,
                        input logic [15:0] za, input logic [15:0] zb,
                        input logic [15:0] zc, input logic [7:0] col);
        load(ax, ay, bx, by, cx, cy, za, zb, zc, col);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        $display("send (%0d,%0d) (%0d,%0d) (%0d,%0d) t=%0t", ax, ay, bx, by, cx, cy, $time);
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (triangle_valid !== 1'b1 && lat < 200) begin
            tick();
            lat++;
        end
        $display("triangle_valid after %0d cycles inv_area=0x%08h", lat, inv_area);
    endtask

    task automatic done_pulse();
        rasterizer_done = 1'b1;
        tick();
        rasterizer_done = 1'b0;
    endtask

    int lat;
    int cnt_a;
    int cnt_b;
    logic first_drop;
    logic ready_k2;

    initial begin
        axi_areset      = 1'b1;
        in_valid        = 1'b0;
        triangle_ready  = 1'b0;
        rasterizer_done = 1'b0;
        load(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) tick();

        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_valid", 32'(triangle_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_dropped", 32'(tri_dropped), 32'd0);
        chk("rst_count", 32'(tri_count), 32'd0);
        chk("rst_inv_area", inv_area, 32'd0);
        chk("rst_v1x", 32'(v1x), 32'd0);
        axi_areset = 1'b0;

        // Reset asserted at the 10th edge after accept, while dividing.
        send(40, 20, 140, 120, 40, 120, 50, 50, 50, 8'hE0);
        repeat (9) tick();
        chk("div_busy", 32'(busy), 32'd1);
        axi_areset = 1'b1;
        tick();
        chk("abort_valid", 32'(triangle_valid), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_in_ready", 32'(in_ready), 32'd1);
        chk("abort_inv_area", inv_area, 32'd0);
        chk("abort_v2x", 32'(v2x), 32'd0);
        chk("abort_color", 32'(color), 32'd0);
        chk("abort_count", 32'(tri_count), 32'd0);
        axi_areset = 1'b0;
        cnt_a = 0;
        repeat (30) begin
            tick();
            if (triangle_valid) cnt_a++;
        end
        chk("abort_no_valid", 32'(cnt_a), 32'd0);

        // Fresh triangle: 2*area 10000, counter-clockwise.
        send(40, 20, 140, 120, 40, 120, 50, 50, 50, 8'hE0);
        wait_valid(lat);
        chk("t1_latency", 32'(lat), 32'd27);
        chk("t1_inv_area", inv_area, 32'h0000068D);
        chk("t1_v2x", 32'(v2x), 32'd140);
        chk("t1_v3y", 32'(v3y), 32'd120);
        chk("t1_z1", 32'(z1), 32'd50);
        chk("t1_color", 32'(color), 32'hE0);
        chk("t1_count_pre", 32'(tri_count), 32'd0);
        triangle_ready = 1'b1;
        tick();
        triangle_ready = 1'b0;
        chk("t1_valid_drop", 32'(triangle_valid), 32'd0);
        chk("t1_count", 32'(tri_count), 32'd1);
        repeat (3) tick();
        chk("t1_wait_done", 32'(busy), 32'd1);
        chk("t1_hold_v2x", 32'(v2x), 32'd140);
        done_pulse();
        chk("t1_idle_busy", 32'(busy), 32'd0);
        chk("t1_idle_ready", 32'(in_ready), 32'd1);

        // 2*area 5000 with a 5-cycle stall on triangle_ready.
        send(140, 20, 190, 70, 90, 70, 7, 8, 9, 8'h03);
        wait_valid(lat);
        chk("t2_latency", 32'(lat), 32'd27);
        chk("t2_inv_area", inv_area, 32'h00000D1B);
        chk("t2_v2x", 32'(v2x), 32'd190);
        chk("t2_v3x", 32'(v3x), 32'd90);
        cnt_a = 0;
        repeat (5) begin
            tick();
            if (triangle_valid === 1'b1 && inv_area === 32'h00000D1B && v2x === 9'd190 &&
                v3x === 9'd90 && v1y === 8'd20 && z3 === 16'd9 && color === 8'h03) cnt_a++;
        end
        chk("t2_stall_stable", 32'(cnt_a), 32'd5);
        chk("t2_stall_count", 32'(tri_count), 32'd1);
        triangle_ready = 1'b1;
        tick();
        triangle_ready = 1'b0;
        chk("t2_count", 32'(tri_count), 32'd2);
        chk("t2_valid_drop", 32'(triangle_valid), 32'd0);
        done_pulse();

        // Clockwise input: v2/v3 and z2/z3 swap; done during the transfer is ignored.
        send(140, 20, 90, 70, 190, 70, 1, 2, 3, 8'h1C);
        wait_valid(lat);
        chk("t3_latency", 32'(lat), 32'd27);
        chk("t3_inv_area", inv_area, 32'h00000D1B);
        chk("t3_v1x", 32'(v1x), 32'd140);
        chk("t3_v2x", 32'(v2x), 32'd190);
        chk("t3_v2y", 32'(v2y), 32'd70);
        chk("t3_v3x", 32'(v3x), 32'd90);
        chk("t3_v3y", 32'(v3y), 32'd70);
        chk("t3_z1", 32'(z1), 32'd1);
        chk("t3_z2", 32'(z2), 32'd3);
        chk("t3_z3", 32'(z3), 32'd2);
        triangle_ready  = 1'b1;
        rasterizer_done = 1'b1;
        tick();
        triangle_ready  = 1'b0;
        rasterizer_done = 1'b0;
        chk("t3_done_in_xfer_ignored", 32'(busy), 32'd1);
        chk("t3_count", 32'(tri_count), 32'd3);
        repeat (2) tick();
        chk("t3_still_waiting", 32'(busy), 32'd1);
        done_pulse();
        chk("t3_idle", 32'(busy), 32'd0);

        // Unit area, then a next triangle held on in_valid across WAIT_DONE.
        send(0, 0, 1, 0, 0, 1, 4, 5, 6, 8'hFF);
        wait_valid(lat);
        chk("t4_latency", 32'(lat), 32'd27);
        chk("t4_inv_area", inv_area, 32'h01000000);
        load(40, 20, 140, 120, 40, 120, 50, 50, 50, 8'hE0);
        in_valid       = 1'b1;
        triangle_ready = 1'b1;
        tick();
        triangle_ready = 1'b0;
        chk("t4_count", 32'(tri_count), 32'd4);
        cnt_a = 0;
        repeat (4) begin
            tick();
            if (in_ready === 1'b0 && busy === 1'b1) cnt_a++;
        end
        chk("cont_blocked", 32'(cnt_a), 32'd4);
        done_pulse();
        chk("cont_ready_after_done", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        chk("cont_accepted_busy", 32'(busy), 32'd1);
        chk("cont_accepted_ready", 32'(in_ready), 32'd0);
        wait_valid(lat);
        chk("cont_latency", 32'(lat), 32'd27);
        chk("cont_inv_area", inv_area, 32'h0000068D);
        triangle_ready = 1'b1;
        tick();
        triangle_ready = 1'b0;
        chk("cont_count", 32'(tri_count), 32'd5);
        done_pulse();

        // Collinear vertices: culled with a single tri_dropped pulse.
        send(10, 10, 20, 20, 30, 30, 1, 1, 1, 8'h55);
        cnt_a      = 0;
        cnt_b      = 0;
        first_drop = 1'b0;
        ready_k2   = 1'b0;
        for (int k = 1; k <= 30; k++) begin
            tick();
            if (tri_dropped) cnt_a++;
            if (triangle_valid) cnt_b++;
            if (k == 1) first_drop = tri_dropped;
            if (k == 2) ready_k2 = in_ready;
        end
        chk("drop_first_cycle", 32'(first_drop), 32'd1);
        chk("drop_pulses", 32'(cnt_a), 32'd1);
        chk("drop_no_valid", 32'(cnt_b), 32'd0);
        chk("drop_in_ready", 32'(ready_k2), 32'd1);
        chk("drop_count", 32'(tri_count), 32'd5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/triangle_setup.md
Name: triangle_setup

Overview:
- Producer-side setup stage that feeds the rasterizer's triangle_valid/triangle_ready/rasterizer_done interface in the AXI-side controller.
- Accepts raw screen-space triangles (vertices, Z, color) from the command path.
- Computes signed 2*area, normalises winding, culls degenerate triangles and computes inv_area with a sequential divider.
- Issues each triangle to the rasterizer and waits for rasterizer_done before accepting the next one.

Parameters:
- FRAC_BITS, 24: inv_area = floor(2^FRAC_BITS / area_x2); divider runs FRAC_BITS+1 iterations.
- WAIT_FOR_DONE, 1: 1 = hold after transfer until rasterizer_done; 0 = return to IDLE right after the transfer.

Ports:
- axi_aclk in 1: clock.
- axi_areset in 1: synchronous reset, active high.
- in_valid in 1: input triangle valid.
- in_ready out 1: block can accept a triangle.
- in_v1x/in_v2x/in_v3x in 9 each: vertex X.
- in_v1y/in_v2y/in_v3y in 8 each: vertex Y.
- in_z1/in_z2/in_z3 in 16 each: vertex depth.
- in_color in 8: RGB332.
- v1x/v2x/v3x out 9, v1y/v2y/v3y out 8, z1/z2/z3 out 16, color out 8: to rasterizer.
- inv_area out 32: 8.24 reciprocal of 2*area.
- triangle_valid out 1: output triangle valid.
- triangle_ready in 1: rasterizer accepts.
- rasterizer_done in 1: rasterizer finished the current triangle.
- busy out 1: state != IDLE.
- tri_dropped out 1: one-cycle pulse on zero-area cull.
- tri_count out 16: triangles transferred, wraps at 0xFFFF -> 0.

Behaviour:
- Reset: state IDLE; in_ready=1; triangle_valid=0; busy=0; tri_dropped=0; tri_count=0; all data outputs 0. Reset in any state aborts the triangle, with no transfer and no count.
- IDLE: in_ready=1. When in_valid&&in_ready, register all inputs and go to AREA. in_ready is 0 in every other state.
- AREA (1 cycle):
  - Signed 20-bit a = x1*(y2-y3) + x2*(y3-y1) + x3*(y1-y2), operands zero-extended then signed.
  - If a==0: pulse tri_dropped, go to IDLE.
  - If a<0: swap v2<->v3 and z2<->z3, and use magnitude -a.
  - The magnitude (area_x2) is held in 18 bits unsigned, max 130305. Go to DIV.
- DIV (FRAC_BITS+1 cycles): restoring division, one quotient bit per cycle, dividend 2^FRAC_BITS, divisor area_x2. Quotient is zero-extended to 32 bits into inv_area. area_x2=1 gives 0x01000000. Then go to ISSUE.
- ISSUE:
  - triangle_valid=1.
  - All outputs are stable and unchanged until the cycle triangle_ready is sampled high. That cycle is the transfer.
  - On transfer: tri_count+=1, triangle_valid drops the next cycle, go to WAIT_DONE (WAIT_FOR_DONE=1) or IDLE (0).
  - triangle_valid never depends combinationally on triangle_ready.
- WAIT_DONE: stay until rasterizer_done=1 is sampled while in this state, then go to IDLE. A rasterizer_done asserted in the transfer cycle itself is ignored.
- Latency: triangle_valid first high exactly FRAC_BITS+3 cycles after the accepting edge (27 at default).
- Throughput: one triangle per (FRAC_BITS+3 + ready wait + done wait + 1) cycles.
- Output registers hold their last values after transfer; they are only updated on a new accept.

Test Plan:
- Accept (40,20),(140,120),(40,120), Z=50, color E0 -> no swap; inv_area=0x0000068D; triangle_valid exactly 27 cycles after accept; tri_count=1.
- Accept (140,20),(190,70),(90,70) -> inv_area=0x00000D1B, no swap. Accept (140,20),(90,70),(190,70), z=(1,2,3) -> v2=(190,70), v3=(90,70), z2=3, z3=2, same inv_area.
- Accept (0,0),(1,0),(0,1) -> inv_area=0x01000000. Accept (10,10),(20,20),(30,30) -> tri_dropped single pulse, no triangle_valid, back in IDLE with in_ready=1 2 cycles after accept.
- Hold triangle_ready=0 for 5 cycles during ISSUE -> triangle_valid and all outputs stable for all 5 cycles; exactly one transfer; tri_count increments once.
- WAIT_FOR_DONE=1:
  - in_valid held high continuously -> second triangle not accepted until the cycle after rasterizer_done.
  - rasterizer_done high in the transfer cycle -> ignored, block stays in WAIT_DONE.
- Assert axi_areset mid-DIV (cycle 10) -> next cycle all outputs at reset values, tri_count unchanged, no triangle_valid; a fresh triangle then completes normally.
